pipe_field_engine: RTL

Parametrised obstacle engine for the VGA flappy game. It holds NUM_PIPES scrolling pipe columns with randomised gaps and advances them once per frame. Each frame it checks the bird box against every pipe and the floor, keeps a score, and runs the IDLE/PLAY/HIT/OVER game FSM. A per-pixel in_pipe flag drives the colour mux beside the image and palette RAMs.

---
 rtl/game_pkg.sv | 30 +++
 rtl/lfsr_galois16.sv | 31 +++
 rtl/pipe_field_engine.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the flappy obstacle engine.
//   - game_state_t : IDLE/PLAY/HIT/OVER encoding driven onto the 'state' port
//   - LFSR_TAPS    : Galois feedback mask for taps 16,14,13,11
//   - DEF_*        : default screen and pipe geometry
//   - rot_byte     : 8-bit window of a 16-bit word starting at a bit offset,
//                    wrapping modulo 16
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_PIPE_W   = 50;
  localparam int DEF_GAP_H    = 100;

  // Concatenating the word with itself makes the modulo-16 wrap a plain shift.
  function automatic logic [7:0] rot_byte(input logic [15:0] value, input int offset);
    logic [31:0] doubled;
    doubled = {value, value} >> (offset % 16);
    return doubled[7:0];
  endfunction

endpackage

// File: rtl/lfsr_galois16.sv
// lfsr_galois16: free-running 16-bit Galois LFSR, advancing every clock.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-low reset, loads SEED
//   value out current LFSR state (never zero)
module lfsr_galois16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] next_value;

  // Right-shifting Galois form; the zero check only matters for a bad seed,
  // since a maximal sequence started from non-zero never reaches zero.
  always_comb begin
    next_value = {1'b0, value[15:1]};
    if (value[0]) next_value = next_value ^ LFSR_TAPS;
    if (next_value == 16'd0) next_value = SEED;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value <= SEED;
    else        value <= next_value;
  end

endmodule

// File: rtl/pipe_field_engine.sv
// pipe_field_engine: scrolling pipe columns, collision, scoring and game FSM.
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   frame_tick        one-clock pulse per frame
//   start             one-clock start/restart pulse
//   x, y              current pixel
//   bird_x, bird_y    bird box top-left corner
//   in_pipe           current pixel is inside a pipe body (combinational)
//   hit               one-clock pulse on collision
//   state             game state (IDLE/PLAY/HIT/OVER)
//   score             pipes passed, saturating at 255
module pipe_field_engine
  import game_pkg::*;
#(
  parameter int          NUM_PIPES   = 5,
  parameter int          PIPE_W      = DEF_PIPE_W,
  parameter int          GAP_H       = DEF_GAP_H,
  parameter int          GAP_MIN     = 40,
  parameter int          GAP_DEFAULT = 190,
  parameter int          SPACING     = 160,
  parameter int          SCREEN_W    = DEF_SCREEN_W,
  parameter int          SCREEN_H    = DEF_SCREEN_H,
  parameter int          SPEED       = 1,
  parameter int          BIRD_W      = 20,
  parameter int          BIRD_H      = 30,
  parameter int          HIT_FREEZE  = 60,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic [9:0] bird_x,
  input  logic [8:0] bird_y,
  output logic       in_pipe,
  output logic       hit,
  output logic [1:0] state,
  output logic [7:0] score
);

  localparam int CNT_W = $clog2(HIT_FREEZE + 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(HIT_FREEZE - 1);

  localparam logic [11:0] PIPE_W12   = 12'(PIPE_W);
  localparam logic [11:0] GAP_H12    = 12'(GAP_H);
  localparam logic [11:0] GAP_MIN12  = 12'(GAP_MIN);
  localparam logic [11:0] GAP_DEF12  = 12'(GAP_DEFAULT);
  localparam logic [11:0] SPEED12    = 12'(SPEED);
  localparam logic [11:0] BIRD_W12   = 12'(BIRD_W);
  localparam logic [11:0] BIRD_H12   = 12'(BIRD_H);
  localparam logic [11:0] SCREEN_H12 = 12'(SCREEN_H);
  localparam logic [11:0] WRAP_ADD12 = 12'(NUM_PIPES * SPACING - SPEED);

  game_state_t          state_q, state_d;
  logic [7:0]           score_q, score_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hit_q, hit_d;
  logic                 scroll, reinit;
  logic [15:0]          lfsr;
  logic [NUM_PIPES-1:0] pix_hit, bird_hit, passed;
  logic [7:0]           pass_cnt;
  logic [8:0]           score_sum;
  logic [7:0]           score_sat;
  logic                 collide;

  logic [11:0] x12, y12, bx12, by12;
  assign x12  = {2'b00, x};
  assign y12  = {3'b000, y};
  assign bx12 = {2'b00, bird_x};
  assign by12 = {3'b000, bird_y};

  lfsr_galois16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr)
  );

  // Each pipe keeps its right edge and gap top; every test below is written
  // as additions so nothing can underflow near the left screen edge.
  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    localparam logic [11:0] R_INIT = 12'(SCREEN_W + PIPE_W + i * SPACING);

    logic [11:0] r_q, gap_q, r_next;
    logic        wrap;

    assign wrap   = r_q < SPEED12;
    assign r_next = wrap ? r_q + WRAP_ADD12 : r_q - SPEED12;

    assign pix_hit[i]  = (x12 < r_q) && (x12 + PIPE_W12 >= r_q) &&
                         ((y12 < gap_q) || (y12 >= gap_q + GAP_H12));
    assign bird_hit[i] = (bx12 < r_q) && (bx12 + BIRD_W12 + PIPE_W12 > r_q) &&
                         ((by12 < gap_q) || (by12 + BIRD_H12 > gap_q + GAP_H12));
    assign passed[i]   = (r_q > bx12) && (r_next <= bx12);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_q   <= R_INIT;
        gap_q <= GAP_DEF12;
      end else if (reinit) begin
        r_q   <= R_INIT;
        gap_q <= GAP_DEF12;
      end else if (scroll) begin
        r_q <= r_next;
        if (wrap) gap_q <= GAP_MIN12 + {4'h0, rot_byte(lfsr, 3 * i)};
      end
    end
  end

  assign in_pipe = |pix_hit;
  assign collide = (|bird_hit) || (by12 + BIRD_H12 > SCREEN_H12);

  // Several pipes may cross the bird in the same frame; add them all, then clamp.
  always_comb begin
    pass_cnt = 8'd0;
    for (int i = 0; i < NUM_PIPES; i++) pass_cnt = pass_cnt + {7'd0, passed[i]};
    score_sum = {1'b0, score_q} + {1'b0, pass_cnt};
    score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  // Next-state logic. start only matters in IDLE/OVER and takes priority
  // over a coincident frame_tick; pipes only move in PLAY without a collision.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    scroll  = 1'b0;
    reinit  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_PLAY;
          score_d = 8'd0;
          reinit  = 1'b1;
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (collide) begin
            hit_d   = 1'b1;
            state_d = ST_HIT;
            cnt_d   = '0;
          end else begin
            scroll  = 1'b1;
            score_d = score_sat;
          end
        end
      end
      ST_HIT: begin
        if (frame_tick) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == FREEZE_LAST) state_d = ST_OVER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      score_q <= 8'd0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
    end
  end

  assign hit   = hit_q;
  assign state = state_q;
  assign score = score_q;

endmodule
